// File: rtl/pulse_gate_if.sv
// Event stream bundle for pulse_gate: AXI-Stream style tdata/tvalid/tlast/tready.
// A beat transfers on the rising clock edge where tvalid and tready are both high.
interface pulse_gate_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/pulse_gate.sv
// Pulse discriminator: tracks peak/width of each vgl pulse, emits accepted events on a stream.
// Optional macro PULSE_GATE_TIMESTAMP_EN adds a second beat carrying the pulse start cycle count.
module pulse_gate #(
    parameter int ADC_WIDTH        = 14,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int MAX_WIDTH        = 1023,
    parameter int DEAD_TIME        = 16
) (
    input  logic                               adc_clk,
    input  logic                               rst,
    input  logic        [AXIS_TDATA_WIDTH-1:0] adc_dat_a,
    input  logic                               vgl,
    input  logic signed [ADC_WIDTH-1:0]        input_high,
    pulse_gate_if.master                       m_axis,
    output logic        [31:0]                 accepted_cnt,
    output logic        [31:0]                 rejected_cnt,
    output logic        [1:0]                  state_dbg_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        EMIT  = 2'd2,
        DEAD  = 2'd3
    } state_t;

    localparam int              DW        = $clog2(DEAD_TIME + 1);
    localparam logic [DW-1:0]   DEAD_LOAD = DW'(DEAD_TIME - 1);
    localparam logic [9:0]      MAX_W     = 10'(MAX_WIDTH);

    state_t                        state_q;
    logic signed [ADC_WIDTH-1:0]   sample_q;
    logic                          vgl_q;
    logic                          armed_q;
    logic signed [ADC_WIDTH-1:0]   peak_q;
    logic        [9:0]             width_q;
    logic        [DW-1:0]          dead_q;
    logic [AXIS_TDATA_WIDTH-1:0]   tdata_q;
    logic                          tvalid_q;
    logic                          tlast_q;
    logic        [31:0]            acc_q;
    logic        [31:0]            rej_q;
    logic [AXIS_TDATA_WIDTH-1:0]   event_word_d;
    logic                          final_beat;
    logic                          unused_ok;

`ifdef PULSE_GATE_TIMESTAMP_EN
    logic [31:0] ts_q;
    logic [31:0] ts_lat_q;
    logic        beat_q;
    assign final_beat = beat_q;
`else
    assign final_beat = 1'b1;
`endif

    assign unused_ok = ^adc_dat_a[AXIS_TDATA_WIDTH-1:ADC_WIDTH];

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        event_word_d                  = '0;
        event_word_d[ADC_WIDTH-1:0]   = peak_q;
        event_word_d[25:16]           = width_q;
    end

    always_ff @(posedge adc_clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            sample_q <= '0;
            vgl_q    <= 1'b0;
            armed_q  <= 1'b0;
            peak_q   <= '0;
            width_q  <= '0;
            dead_q   <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            acc_q    <= '0;
            rej_q    <= '0;
`ifdef PULSE_GATE_TIMESTAMP_EN
            ts_q     <= '0;
            ts_lat_q <= '0;
            beat_q   <= 1'b0;
`endif
        end else begin
            sample_q <= adc_dat_a[ADC_WIDTH-1:0];
            vgl_q    <= vgl;
            // A vgl already high out of reset must fall once before an edge counts.
            if (!vgl) armed_q <= 1'b1;
`ifdef PULSE_GATE_TIMESTAMP_EN
            ts_q <= ts_q + 32'd1;
`endif
            case (state_q)
                IDLE: begin
                    if (vgl && !vgl_q && armed_q) begin
                        state_q <= TRACK;
                        peak_q  <= sample_q;
                        width_q <= 10'd1;
`ifdef PULSE_GATE_TIMESTAMP_EN
                        ts_lat_q <= ts_q;
`endif
                    end
                end
                TRACK: begin
                    if (vgl) begin
                        if (width_q == MAX_W) begin
                            rej_q   <= sat_inc(rej_q);
                            dead_q  <= DEAD_LOAD;
                            state_q <= DEAD;
                        end else begin
                            if (sample_q > peak_q) peak_q <= sample_q;
                            width_q <= width_q + 10'd1;
                        end
                    end else if (peak_q <= input_high) begin
                        tdata_q  <= event_word_d;
                        tvalid_q <= 1'b1;
`ifdef PULSE_GATE_TIMESTAMP_EN
                        tlast_q  <= 1'b0;
                        beat_q   <= 1'b0;
`else
                        tlast_q  <= 1'b1;
`endif
                        state_q  <= EMIT;
                    end else begin
                        rej_q   <= sat_inc(rej_q);
                        dead_q  <= DEAD_LOAD;
                        state_q <= DEAD;
                    end
                end
                EMIT: begin
                    if (m_axis.tready) begin
                        if (final_beat) begin
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            acc_q    <= sat_inc(acc_q);
                            dead_q   <= DEAD_LOAD;
                            state_q  <= DEAD;
                        end
`ifdef PULSE_GATE_TIMESTAMP_EN
                        else begin
                            beat_q  <= 1'b1;
                            tdata_q <= AXIS_TDATA_WIDTH'(ts_lat_q);
                            tlast_q <= 1'b1;
                        end
`endif
                    end
                end
                DEAD: begin
                    if (dead_q == '0) state_q <= IDLE;
                    else              dead_q  <= dead_q - DW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign accepted_cnt  = acc_q;
    assign rejected_cnt  = rej_q;
    assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_pulse_gate.sv
// Bench for pulse_gate: directed vector table, hand-written corner sequences,
// and a randomized run scored against a pulse-level reference model.
module tb_pulse_gate;

    localparam int DWID   = 32;
    localparam int MAXW   = 1023;
    localparam int DEADT  = 16;
    localparam int N_RAND = 3000;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TRACK = 2'd1;
    localparam logic [1:0] S_EMIT  = 2'd2;
    localparam logic [1:0] S_DEAD  = 2'd3;
`ifdef PULSE_GATE_TIMESTAMP_EN
    localparam int BEATS = 2;
`else
    localparam int BEATS = 1;
`endif

    // clock / reset
    logic               adc_clk = 1'b0;
    logic               rst = 1'b0;
    logic [31:0]        adc_dat_a = '0;
    logic               vgl = 1'b0;
    logic signed [13:0] input_high = '0;
    logic [31:0]        accepted_cnt;
    logic [31:0]        rejected_cnt;
    logic [1:0]         state_dbg;

    pulse_gate_if #(.DATA_W(DWID)) m_axis ();

    pulse_gate dut (
        .adc_clk      (adc_clk),
        .rst          (rst),
        .adc_dat_a    (adc_dat_a),
        .vgl          (vgl),
        .input_high   (input_high),
        .m_axis       (m_axis),
        .accepted_cnt (accepted_cnt),
        .rejected_cnt (rejected_cnt),
        .state_dbg_o  (state_dbg)
    );

    always #5 adc_clk = ~adc_clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        f_prev = 1'b0;
    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];

    // monitor: record every beat that transfers at the next rising edge
    always @(negedge adc_clk) begin
        if (rst === 1'b1 && m_axis.tvalid === 1'b1 && m_axis.tready === 1'b1)
            got_q.push_back({m_axis.tlast, m_axis.tdata});
    end

    initial begin
        #2000000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ev_word(input int pk, input int w);
        logic [31:0] x;
        x = '0;
        x[13:0]  = 14'(pk);
        x[25:16] = 10'(w);
        return x;
    endfunction

    // driver: sample s now, its threshold flag f one cycle later
    task automatic drive(input int s, input logic f);
        logic [31:0] w;
        w = $urandom();
        w[13:0] = 14'(s);
        adc_dat_a = w;
        vgl = f_prev;
        f_prev = f;
        @(posedge adc_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        m_axis.tready = 1'b1;
        vgl = 1'b0;
        f_prev = 1'b0;
        adc_dat_a = '0;
        repeat (3) @(posedge adc_clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic pulse3(input int a, input int b, input int c);
        drive(a, 1'b1);
        drive(b, 1'b1);
        drive(c, 1'b1);
        drive(0, 1'b0);
        drive(0, 1'b0);
    endtask

    typedef struct {
        int len;
        int s_base;
        int s_peak;
        int peak_at;
        int high;
        bit accept;
        int exp_peak;
        int exp_width;
    } vec_t;

    vec_t vecs[9];

    // random-phase arrays, indexed by aligned sample index
    int s_a[N_RAND];
    int h_a[N_RAND];
    bit f_a[N_RAND];
    bit r_a[N_RAND];

    function automatic bit flag_at(input int j);
        return (j < 0) ? 1'b0 : f_a[j];
    endfunction

    initial begin
        logic [31:0] a0, r0;
        logic [32:0] exp_first;
        int dead_seen, bad_cycles;

        vecs[0] = '{3, 100, 500, 1, 8000, 1'b1, 500, 3};
        vecs[1] = '{3, 100, 500, 1, 400, 1'b0, 0, 0};
        vecs[2] = '{3, -80, -20, 2, 0, 1'b1, -20, 3};
        vecs[3] = '{1, 700, 700, 0, 700, 1'b1, 700, 1};
        vecs[4] = '{1, 701, 701, 0, 700, 1'b0, 0, 0};
        vecs[5] = '{2, -8192, 8191, 1, 8191, 1'b1, 8191, 2};
        vecs[6] = '{1023, 7, 9, 1022, 8000, 1'b1, 9, 1023};
        vecs[7] = '{1024, 7, 9, 5, 8000, 1'b0, 0, 0};
        vecs[8] = '{4, 5, 5, 0, -8192, 1'b0, 0, 0};

        m_axis.tready = 1'b1;
        #1;
        check("reset_tvalid", m_axis.tvalid, 1'b0);
        check("reset_tdata", m_axis.tdata, 32'd0);
        check("reset_acc", accepted_cnt, 32'd0);
        check("reset_state", state_dbg, S_IDLE);
        do_reset();
        idle(3);

        // table-driven single pulses
        for (int i = 0; i < 9; i++) begin
            input_high = 14'(vecs[i].high);
            got_q.delete();
            a0 = accepted_cnt;
            r0 = rejected_cnt;
            for (int k = 0; k < vecs[i].len; k++)
                drive((k == vecs[i].peak_at) ? vecs[i].s_peak : vecs[i].s_base, 1'b1);
            idle(DEADT + 12);
            if (vecs[i].accept) begin
                exp_first = {1'(BEATS == 1), ev_word(vecs[i].exp_peak, vecs[i].exp_width)};
                check($sformatf("vec%0d_beats", i), got_q.size(), BEATS);
                if (got_q.size() > 0) check($sformatf("vec%0d_word", i), got_q[0], exp_first);
                check($sformatf("vec%0d_acc", i), accepted_cnt, a0 + 1);
                check($sformatf("vec%0d_rej", i), rejected_cnt, r0);
            end else begin
                check($sformatf("vec%0d_beats", i), got_q.size(), 0);
                check($sformatf("vec%0d_acc", i), accepted_cnt, a0);
                check($sformatf("vec%0d_rej", i), rejected_cnt, r0 + 1);
            end
        end

        // reject, then exact dead time; pulse rising during dead and still high is ignored
        input_high = 14'sd400;
        r0 = rejected_cnt;
        drive(100, 1'b1);
        drive(500, 1'b1);
        drive(300, 1'b1);
        drive(0, 1'b0);
        check("track_state", state_dbg, S_TRACK);
        drive(0, 1'b0);
        dead_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (state_dbg == S_DEAD) dead_seen++;
            else break;
            drive(200, 1'b1);
        end
        check("dead_len", dead_seen, DEADT);
        check("dead_exit_idle", state_dbg, S_IDLE);
        check("reject_cnt", rejected_cnt, r0 + 1);
        repeat (5) drive(200, 1'b1);
        check("held_no_capture", state_dbg, S_IDLE);
        idle(3);

        // long pulse aborts; no recapture until vgl falls and rises
        input_high = 14'sd8000;
        got_q.delete();
        r0 = rejected_cnt;
        repeat (2000) drive(100, 1'b1);
        check("abort_rej", rejected_cnt, r0 + 1);
        check("abort_idle", state_dbg, S_IDLE);
        check("abort_no_event", got_q.size(), 0);
        idle(2);
        pulse3(300, 300, 300);
        idle(DEADT + 10);
        check("after_abort_beats", got_q.size(), BEATS);
        if (got_q.size() > 0) check("after_abort_word", got_q[0][31:0], ev_word(300, 3));

        // backpressure: tdata stable for 50 stalled cycles, second pulse ignored
        got_q.delete();
        a0 = accepted_cnt;
        m_axis.tready = 1'b0;
        pulse3(100, 500, 300);
        bad_cycles = 0;
        for (int k = 0; k < 50; k++) begin
            if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== ev_word(500, 3)
                || m_axis.tlast !== 1'(BEATS == 1)) bad_cycles++;
            drive(900, (k >= 10 && k < 20));
        end
        check("stall_stable", bad_cycles, 0);
        m_axis.tready = 1'b1;
        idle(DEADT + 12);
        check("stall_beats", got_q.size(), BEATS);
        if (got_q.size() > 0) check("stall_word", got_q[0][31:0], ev_word(500, 3));
        check("stall_acc", accepted_cnt, a0 + 1);

        // reset while tvalid is high; release with vgl already high
        m_axis.tready = 1'b0;
        pulse3(100, 500, 300);
        check("pre_rst_valid", m_axis.tvalid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_tvalid", m_axis.tvalid, 1'b0);
        check("rst_acc", accepted_cnt, 32'd0);
        check("rst_rej", rejected_cnt, 32'd0);
        check("rst_state", state_dbg, S_IDLE);
        f_prev = 1'b1;
        vgl = 1'b1;
        m_axis.tready = 1'b1;
        @(posedge adc_clk);
        #1;
        rst = 1'b1;
        got_q.delete();
        repeat (20) drive(300, 1'b1);
        check("rst_high_vgl_idle", state_dbg, S_IDLE);
        check("rst_high_vgl_none", got_q.size(), 0);
        idle(2);
        pulse3(100, 500, 300);
        idle(DEADT + 10);
        check("post_rst_beats", got_q.size(), BEATS);
        if (got_q.size() > 0) check("post_rst_word", got_q[0][31:0], ev_word(500, 3));
        check("post_rst_acc", accepted_cnt, 32'd1);

        // randomized run against the pulse-level model
        begin
            int idx, gap, plen, j, e, L, d, k, pk, free_at, e_acc, e_rej;
            idx = 0;
            for (int i = 0; i < N_RAND; i++) begin
                f_a[i] = 1'b0;
                s_a[i] = int'($urandom_range(0, 4000)) - 2000;
                h_a[i] = int'($urandom_range(0, 3000)) - 1000;
                r_a[i] = (i >= N_RAND - 100) ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
            while (idx < N_RAND - 100) begin
                gap = $urandom_range(1, 20);
                plen = $urandom_range(1, 30);
                idx += gap;
                for (int p = 0; p < plen && idx < N_RAND - 100; p++) begin
                    f_a[idx] = 1'b1;
                    idx++;
                end
            end

            exp_q.delete();
            e_acc = 0;
            e_rej = 0;
            j = 0;
            free_at = 0;
            while (j < N_RAND) begin
                if (j >= free_at && flag_at(j) && !flag_at(j - 1)) begin
                    e = j;
                    L = 0;
                    while (e + L < N_RAND && f_a[e + L]) L++;
                    if (L > MAXW) begin
                        d = e + MAXW;
                        e_rej++;
                        free_at = d + 1 + DEADT;
                    end else begin
                        d = e + L;
                        pk = s_a[e];
                        for (int p = e; p < e + L; p++) if (s_a[p] > pk) pk = s_a[p];
                        if (pk <= h_a[d]) begin
                            k = d + 1;
                            while (k < N_RAND && !r_a[k]) k++;
                            exp_q.push_back({1'(BEATS == 1), ev_word(pk, L)});
`ifdef PULSE_GATE_TIMESTAMP_EN
                            k++;
                            while (k < N_RAND && !r_a[k]) k++;
                            exp_q.push_back({1'b1, 32'(e + 1)});
`endif
                            e_acc++;
                            free_at = k + 1 + DEADT;
                        end else begin
                            e_rej++;
                            free_at = d + 1 + DEADT;
                        end
                    end
                    j = free_at;
                end else begin
                    j++;
                end
            end

            do_reset();
            got_q.delete();
            for (int c = 0; c <= N_RAND; c++) begin
                m_axis.tready = (c == 0) ? 1'b1 : r_a[c - 1];
                input_high = (c == 0) ? 14'sd0 : 14'(h_a[c - 1]);
                if (c < N_RAND) drive(s_a[c], f_a[c]);
                else drive(0, 1'b0);
            end
            m_axis.tready = 1'b1;
            idle(DEADT + 10);

            check("rand_event_count", got_q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
                check($sformatf("rand_beat%0d", i), got_q[i], exp_q[i]);
            check("rand_acc", accepted_cnt, 32'(e_acc));
            check("rand_rej", rejected_cnt, 32'(e_rej));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
